// File: rtl/dfp_burst_responder_if.sv
// Bus bundle between the cache's downstream-facing port and the burst memory.
//   dfp_*  : line-level request/response (cache side)
//   bmem_* : 64-bit beat-level burst channel (memory side)
// Modports:
//   master : cache + memory side (drives dfp requests and bmem responses)
//   slave  : responder (consumes dfp requests, drives bmem commands/beats)
interface dfp_burst_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4
);
  localparam int unsigned LINE_W = BEAT_W * BEATS;

  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/dfp_burst_responder.sv
// Responder for the cache's downstream-facing port. Each 256-bit line read or
// write becomes a 4-beat 64-bit burst on the bmem channel; one single-cycle
// dfp_resp is returned per request.
// Ports:
//   clk : clock
//   rst : asynchronous reset, active-high
//   bus : dfp_burst_responder_if.slave (dfp request/response, bmem burst)
module dfp_burst_responder #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  dfp_burst_responder_if.slave        bus
);
  localparam int unsigned OFF_W = $clog2(BEAT_W * BEATS / 8);
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_BEAT,
    WR_BEAT,
    RESP,
    DONE
  } state_t;

  state_t                       state, next;
  logic [CNT_W-1:0]             beat;
  logic [ADDR_W-1:0]            addr_q;
  logic [BEATS-1:0][BEAT_W-1:0] wdata_q;
  logic [BEATS-1:0][BEAT_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Beat counter wraps back to 0 naturally on the last beat of each burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dfp_read || bus.dfp_write) begin
            addr_q <= bus.dfp_addr & ADDR_MASK;
            beat   <= '0;
            if (bus.dfp_write) wdata_q <= bus.dfp_wdata;
          end
        end
        RD_BEAT: begin
          if (bus.bmem_rvalid) begin
            rdata_q[beat] <= bus.bmem_rdata;
            beat          <= beat + CNT_W'(1);
          end
        end
        WR_BEAT: begin
          if (bus.bmem_ready) beat <= beat + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next           = state;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_addr  = '0;
    bus.bmem_wdata = '0;
    bus.dfp_resp   = 1'b0;
    case (state)
      IDLE: begin
        // Write takes priority when both requests are raised together.
        if (bus.dfp_write)     next = WR_BEAT;
        else if (bus.dfp_read) next = RD_CMD;
      end
      RD_CMD: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
        if (bus.bmem_ready) next = RD_BEAT;
      end
      RD_BEAT: begin
        if (bus.bmem_rvalid && beat == LAST_BEAT) next = RESP;
      end
      WR_BEAT: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = wdata_q[beat];
        if (bus.bmem_ready && beat == LAST_BEAT) next = RESP;
      end
      RESP: begin
        bus.dfp_resp = 1'b1;
        next         = DONE;
      end
      // Guard cycle: the cache is still dropping its request here.
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign bus.dfp_rdata = rdata_q;
endmodule

// File: tb/tb_dfp_burst_responder.sv
// Self-checking bench for dfp_burst_responder. A cycle-stepping task plays the
// cache (request hold/drop) and the burst memory (ready, read beats), and
// records what the responder emits; each test compares against expectations
// derived from the line/beat rules.
module tb_dfp_burst_responder;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dfp_burst_responder_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) bus ();

  dfp_burst_responder #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // memory-side behaviour knobs
  bit ready_rand  = 1'b0;
  bit rv_gap_rand = 1'b0;
  bit stray       = 1'b0;
  int rv_delay    = 0;
  int ready_q[$];
  logic [3:0][63:0] rd_line;
  int beat_idx = -1;
  int wait_cnt = 0;
  int rv_cnt   = 0;

  // observations
  int resp_cnt = 0;
  int resp_cyc = 0;
  logic [255:0] resp_data;
  int rd_cmd_cnt = 0;
  int rd_cmd_cyc = 0;
  int rd_high    = 0;
  logic [31:0] rd_cmd_addr;
  logic [63:0] wr_beats[$];
  logic [31:0] wr_addr_seen;
  int hold_err = 0;

  // cache-side behaviour
  int drop_at    = -1;
  int hold_extra = 0;

  // reference: what dfp_rdata must hold after the most recent completed read
  logic [255:0] model_rdata = '0;

  function automatic logic [255:0] rnd_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic cycle();
    bit acc_rd, acc_wr, stall;
    logic [63:0] pw;
    logic [31:0] pa;
    int r;
    acc_rd = bus.bmem_read  && bus.bmem_ready && !rst;
    acc_wr = bus.bmem_write && bus.bmem_ready && !rst;
    stall  = bus.bmem_write && !bus.bmem_ready && !rst;
    pw = bus.bmem_wdata;
    pa = bus.bmem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_rd) begin
      rd_cmd_cnt++;
      rd_cmd_cyc  = cyc - 1;
      rd_cmd_addr = pa;
      beat_idx    = 0;
      wait_cnt    = rv_delay;
    end
    if (acc_wr) begin
      wr_beats.push_back(pw);
      wr_addr_seen = pa;
    end
    if (stall && (bus.bmem_write !== 1'b1 || bus.bmem_wdata !== pw || bus.bmem_addr !== pa))
      hold_err++;
    if (bus.dfp_resp === 1'b1) begin
      resp_cnt++;
      resp_cyc  = cyc;
      resp_data = bus.dfp_rdata;
      if (drop_at < 0) drop_at = cyc + 1 + hold_extra;
    end
    if (bus.bmem_read === 1'b1) rd_high++;
    if (cyc == drop_at) begin
      bus.dfp_read  = 1'b0;
      bus.dfp_write = 1'b0;
      drop_at       = -1;
    end
    if ((bus.bmem_read || bus.bmem_write) && ready_q.size() > 0) begin
      r = ready_q.pop_front();
      bus.bmem_ready = (r != 0);
    end else begin
      bus.bmem_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    bus.bmem_rvalid = 1'b0;
    bus.bmem_rdata  = {$urandom, $urandom};
    if (beat_idx >= 0) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        bus.bmem_rvalid = 1'b1;
        bus.bmem_rdata  = rd_line[beat_idx];
        rv_cnt++;
        beat_idx++;
        if (beat_idx == BEATS) beat_idx = -1;
        wait_cnt = rv_gap_rand ? int'($urandom_range(0, 2)) : 0;
      end
    end else if (stray) begin
      bus.bmem_rvalid = 1'b1;
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] wd, input int hx);
    bus.dfp_read  = rd;
    bus.dfp_write = wr;
    bus.dfp_addr  = a;
    bus.dfp_wdata = wd;
    hold_extra    = hx;
    drop_at       = -1;
  endtask

  task automatic wait_resp(input int base, input int budget);
    for (int i = 0; i < budget && resp_cnt == base; i++) cycle();
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    checks++; if (bus.dfp_resp !== 1'b0) $display("FAIL rst_resp: got %b expected 0", bus.dfp_resp); else passes++;
    checks++; if (bus.bmem_read !== 1'b0) $display("FAIL rst_bmem_read: got %b expected 0", bus.bmem_read); else passes++;
    checks++; if (bus.bmem_write !== 1'b0) $display("FAIL rst_bmem_write: got %b expected 0", bus.bmem_write); else passes++;
    checks++; if (bus.bmem_addr !== 32'h0) $display("FAIL rst_bmem_addr: got %h expected 0", bus.bmem_addr); else passes++;
    checks++; if (bus.bmem_wdata !== 64'h0) $display("FAIL rst_bmem_wdata: got %h expected 0", bus.bmem_wdata); else passes++;
    checks++; if (bus.dfp_rdata !== 256'h0) $display("FAIL rst_dfp_rdata: got %h expected 0", bus.dfp_rdata); else passes++;
    bus.dfp_write = 1'b1;
    cycle();
    checks++; if (bus.bmem_write !== 1'b0) $display("FAIL rst_holds_idle: got bmem_write=%b expected 0", bus.bmem_write); else passes++;
    bus.dfp_write = 1'b0;
    rst = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_read_basic();
    int t0, base, cb;
    logic [255:0] exp;
    ready_q.delete(); ready_rand = 1'b0; rv_gap_rand = 1'b0; rv_delay = 1;
    for (int k = 0; k < 4; k++) rd_line[k] = 64'hAAAA_AAAA_AAAA_AAA0 | 64'(k);
    exp = {rd_line[3], rd_line[2], rd_line[1], rd_line[0]};
    t0 = cyc; base = resp_cnt; cb = rd_cmd_cnt;
    issue(1'b1, 1'b0, 32'h1234_5678, '0, 0);
    wait_resp(base, 40);
    repeat (4) cycle();
    checks++; if (rd_cmd_addr !== 32'h1234_5660) $display("FAIL rd_addr: got %h expected 12345660", rd_cmd_addr); else passes++;
    checks++; if (rd_cmd_cnt - cb != 1) $display("FAIL rd_cmd_count: got %0d expected 1", rd_cmd_cnt - cb); else passes++;
    checks++; if (resp_cnt - base != 1) $display("FAIL rd_resp_count: got %0d expected 1", resp_cnt - base); else passes++;
    checks++; if (resp_cyc - t0 != 7) $display("FAIL rd_latency: got %0d expected 7", resp_cyc - t0); else passes++;
    checks++; if (resp_data !== exp) $display("FAIL rd_data: got %h expected %h", resp_data, exp); else passes++;
    model_rdata = exp;
  endtask

  task automatic test_write_stall();
    int t0, base, wb, he, cb;
    logic [255:0] wd;
    wd = rnd_line();
    ready_q.delete(); ready_rand = 1'b0;
    ready_q = '{1, 0, 1, 1, 0, 1};
    t0 = cyc; base = resp_cnt; wb = wr_beats.size(); he = hold_err; cb = rd_cmd_cnt;
    issue(1'b0, 1'b1, 32'h0000_0040, wd, 0);
    wait_resp(base, 40);
    repeat (4) cycle();
    checks++; if (wr_beats.size() - wb != 4) $display("FAIL wr_beat_count: got %0d expected 4", wr_beats.size() - wb); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_beats.size() > wb + k && wr_beats[wb+k] === wd[64*k +: 64]) passes++;
      else $display("FAIL wr_beat%0d: got %h expected %h", k,
                    (wr_beats.size() > wb + k) ? wr_beats[wb+k] : 64'hx, wd[64*k +: 64]);
    end
    checks++; if (wr_addr_seen !== 32'h0000_0040) $display("FAIL wr_addr: got %h expected 00000040", wr_addr_seen); else passes++;
    checks++; if (hold_err != he) $display("FAIL wr_stall_hold: got %0d violations expected 0", hold_err - he); else passes++;
    checks++; if (resp_cnt - base != 1) $display("FAIL wr_resp_count: got %0d expected 1", resp_cnt - base); else passes++;
    checks++; if (resp_cyc - t0 != 7) $display("FAIL wr_latency: got %0d expected 7", resp_cyc - t0); else passes++;
    checks++; if (resp_data !== model_rdata) $display("FAIL wr_rdata_kept: got %h expected %h", resp_data, model_rdata); else passes++;
    checks++; if (rd_cmd_cnt != cb) $display("FAIL wr_no_read: got %0d expected 0", rd_cmd_cnt - cb); else passes++;
  endtask

  task automatic test_held_read();
    int base, cb;
    logic [31:0] a;
    logic [255:0] exp;
    ready_q.delete(); ready_rand = 1'b1; rv_gap_rand = 1'b1; rv_delay = int'($urandom_range(0, 3));
    rd_line = rnd_line();
    exp = {rd_line[3], rd_line[2], rd_line[1], rd_line[0]};
    a = $urandom;
    base = resp_cnt; cb = rd_cmd_cnt;
    issue(1'b1, 1'b0, a, '0, 1);
    wait_resp(base, 100);
    repeat (8) cycle();
    checks++; if (rd_cmd_cnt - cb != 1) $display("FAIL held_cmd_count: got %0d expected 1", rd_cmd_cnt - cb); else passes++;
    checks++; if (resp_cnt - base != 1) $display("FAIL held_resp_count: got %0d expected 1", resp_cnt - base); else passes++;
    checks++; if (resp_data !== exp) $display("FAIL held_data: got %h expected %h", resp_data, exp); else passes++;
    checks++; if (rd_cmd_addr !== {a[31:5], 5'b0}) $display("FAIL held_addr: got %h expected %h", rd_cmd_addr, {a[31:5], 5'b0}); else passes++;
    model_rdata = exp;
  endtask

  task automatic test_both();
    int base, wb, rh;
    logic [31:0] a;
    logic [255:0] wd, got;
    ready_q.delete(); ready_rand = 1'b1;
    wd = rnd_line(); a = $urandom;
    base = resp_cnt; wb = wr_beats.size(); rh = rd_high;
    issue(1'b1, 1'b1, a, wd, 0);
    wait_resp(base, 100);
    repeat (4) cycle();
    got = '0;
    for (int k = 0; k < 4; k++) if (wr_beats.size() > wb + k) got[64*k +: 64] = wr_beats[wb+k];
    checks++; if (rd_high != rh) $display("FAIL both_no_read: got %0d bmem_read cycles expected 0", rd_high - rh); else passes++;
    checks++; if (wr_beats.size() - wb != 4) $display("FAIL both_beats: got %0d expected 4", wr_beats.size() - wb); else passes++;
    checks++; if (got !== wd) $display("FAIL both_data: got %h expected %h", got, wd); else passes++;
    checks++; if (resp_cnt - base != 1) $display("FAIL both_resp: got %0d expected 1", resp_cnt - base); else passes++;
    checks++; if (wr_addr_seen !== {a[31:5], 5'b0}) $display("FAIL both_addr: got %h expected %h", wr_addr_seen, {a[31:5], 5'b0}); else passes++;
  endtask

  task automatic test_reset_abort();
    int base, rv0;
    logic [255:0] exp;
    ready_q.delete(); ready_rand = 1'b0; rv_gap_rand = 1'b0; rv_delay = 0;
    rd_line = rnd_line();
    base = resp_cnt; rv0 = rv_cnt;
    issue(1'b1, 1'b0, $urandom, '0, 0);
    for (int i = 0; i < 20 && rv_cnt - rv0 < 2; i++) cycle();
    cycle();
    rst = 1'b1;
    bus.dfp_read = 1'b0;
    beat_idx = -1;
    bus.bmem_rvalid = 1'b0;
    model_rdata = '0;
    #1;
    checks++; if (bus.dfp_rdata !== 256'h0) $display("FAIL abort_rdata_cleared: got %h expected 0", bus.dfp_rdata); else passes++;
    checks++; if (bus.bmem_read !== 1'b0 || bus.dfp_resp !== 1'b0) $display("FAIL abort_outputs: got read=%b resp=%b expected 0 0", bus.bmem_read, bus.dfp_resp); else passes++;
    cycle();
    rst = 1'b0;
    stray = 1'b1;
    repeat (4) cycle();
    stray = 1'b0;
    repeat (2) cycle();
    checks++; if (resp_cnt != base) $display("FAIL abort_no_resp: got %0d expected 0", resp_cnt - base); else passes++;
    checks++; if (bus.dfp_rdata !== 256'h0) $display("FAIL stray_rvalid: got %h expected 0", bus.dfp_rdata); else passes++;
    rd_line = rnd_line();
    exp = {rd_line[3], rd_line[2], rd_line[1], rd_line[0]};
    rv_gap_rand = 1'b1;
    issue(1'b1, 1'b0, $urandom, '0, 0);
    wait_resp(base, 60);
    repeat (3) cycle();
    checks++; if (resp_cnt - base != 1) $display("FAIL abort_new_resp: got %0d expected 1", resp_cnt - base); else passes++;
    checks++; if (resp_data !== exp) $display("FAIL abort_new_data: got %h expected %h", resp_data, exp); else passes++;
    model_rdata = exp;
  endtask

  task automatic test_back_to_back();
    int base, wb, wresp;
    logic [255:0] wd, got, exp;
    ready_q.delete(); ready_rand = 1'b0; rv_gap_rand = 1'b0; rv_delay = 0;
    wd = rnd_line();
    rd_line = rnd_line();
    exp = {rd_line[3], rd_line[2], rd_line[1], rd_line[0]};
    base = resp_cnt; wb = wr_beats.size();
    issue(1'b0, 1'b1, $urandom, wd, 0);
    wait_resp(base, 40);
    wresp = resp_cyc;
    cycle();
    issue(1'b1, 1'b0, $urandom, '0, 0);
    wait_resp(base + 1, 40);
    repeat (3) cycle();
    got = '0;
    for (int k = 0; k < 4; k++) if (wr_beats.size() > wb + k) got[64*k +: 64] = wr_beats[wb+k];
    checks++; if (got !== wd) $display("FAIL b2b_wdata: got %h expected %h", got, wd); else passes++;
    checks++; if (rd_cmd_cyc - wresp != 3) $display("FAIL b2b_accept_gap: got %0d expected 3", rd_cmd_cyc - wresp); else passes++;
    checks++; if (resp_cnt - base != 2) $display("FAIL b2b_resp_count: got %0d expected 2", resp_cnt - base); else passes++;
    checks++; if (resp_data !== exp) $display("FAIL b2b_rdata: got %h expected %h", resp_data, exp); else passes++;
    model_rdata = exp;
  endtask

  task automatic test_random();
    int base, wb, cb, op;
    logic [31:0] a;
    logic [255:0] wd, got, exp;
    for (int it = 0; it < 12; it++) begin
      ready_q.delete();
      ready_rand  = ($urandom_range(0, 1) == 1);
      rv_gap_rand = ($urandom_range(0, 1) == 1);
      rv_delay    = int'($urandom_range(0, 2));
      op = int'($urandom_range(0, 2));
      a = $urandom; wd = rnd_line(); rd_line = rnd_line();
      exp = {rd_line[3], rd_line[2], rd_line[1], rd_line[0]};
      base = resp_cnt; wb = wr_beats.size(); cb = rd_cmd_cnt;
      issue(op != 1, op != 0, a, wd, int'($urandom_range(0, 1)));
      wait_resp(base, 200);
      repeat (int'($urandom_range(2, 4))) cycle();
      checks++; if (resp_cnt - base != 1) $display("FAIL rnd%0d_resp: got %0d expected 1", it, resp_cnt - base); else passes++;
      if (op == 0) begin
        checks++; if (resp_data !== exp) $display("FAIL rnd%0d_rdata: got %h expected %h", it, resp_data, exp); else passes++;
        checks++; if (rd_cmd_addr !== {a[31:5], 5'b0}) $display("FAIL rnd%0d_raddr: got %h expected %h", it, rd_cmd_addr, {a[31:5], 5'b0}); else passes++;
        model_rdata = exp;
      end else begin
        got = '0;
        for (int k = 0; k < 4; k++) if (wr_beats.size() > wb + k) got[64*k +: 64] = wr_beats[wb+k];
        checks++; if (got !== wd || wr_beats.size() - wb != 4) $display("FAIL rnd%0d_wdata: got %h (%0d beats) expected %h", it, got, wr_beats.size() - wb, wd); else passes++;
        checks++; if (rd_cmd_cnt != cb) $display("FAIL rnd%0d_no_read: got %0d expected 0", it, rd_cmd_cnt - cb); else passes++;
        checks++; if (resp_data !== model_rdata) $display("FAIL rnd%0d_rdata_kept: got %h expected %h", it, resp_data, model_rdata); else passes++;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.dfp_addr    = '0;
    bus.dfp_read    = 1'b0;
    bus.dfp_write   = 1'b0;
    bus.dfp_wdata   = '0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_rdata  = '0;
    bus.bmem_rvalid = 1'b0;
    rd_line         = '0;
    test_reset();
    test_read_basic();
    test_write_stall();
    test_held_read();
    test_both();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
